dff_exerciser: RTL and testbench
================================

DFF_EXERCISER -- requirements
Module: dff_exerciser

Interface
REQ-001 Parameter WIDTH, default 4, data width of the driven DFF interface.
REQ-002 Parameter NUM_VECTORS, default 16, data vectors driven per run (1..255).
REQ-003 Parameter RST_CYCLES, default 2, cycles dut_rst is held high per run (1..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle run request; sampled only in IDLE.
REQ-007 seed  input  8  LFSR seed, captured on accepted start.
REQ-008 dut_q  input  WIDTH  registered output returned by the DFF under test.
REQ-009 dut_rst  output  1  reset driven to the DFF under test.
REQ-010 dut_d  output  WIDTH  data driven to the DFF under test.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at run end.
REQ-013 pass  output  1  high when the last run had zero mismatches; held until next accepted start.
REQ-014 err_count  output  8  mismatches in current or last run, saturating at 255.

Function
REQ-015 The FSM SHALL have states IDLE, ASSERT_RST, DRIVE, DRAIN, DONE.
REQ-016 IDLE to ASSERT_RST on start=1; start in any other state is ignored; an accepted start clears err_count and pass and loads the LFSR with seed, or with 8'h01 if seed==0.
REQ-017 ASSERT_RST SHALL drive dut_rst=1 and dut_d=0 for exactly RST_CYCLES cycles, then go to DRIVE.
REQ-018 DRIVE SHALL drive dut_rst=0 and dut_d=lfsr[WIDTH-1:0] for exactly NUM_VECTORS cycles; the LFSR advances once per DRIVE cycle.
REQ-019 LFSR SHALL be 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift-left, feedback into bit 0.
REQ-020 DRAIN SHALL last one cycle with dut_rst=0 and dut_d held at the last vector, then go to DONE.
REQ-021 DONE SHALL last one cycle, assert done=1, set pass=(err_count==0), then go to IDLE.
REQ-022 Expected-value register exp_q SHALL update every edge: 0 if dut_rst was 1, else dut_d.
REQ-023 Compare SHALL be enabled from the second ASSERT_RST cycle through the DRAIN cycle inclusive; when enabled and dut_q!=exp_q, err_count increments.
REQ-024 Model assumption: the DUT captures D, or clears to 0 under its reset, on the same edge; one-cycle latency.
REQ-025 err_count SHALL hold at 255 once reached.
REQ-026 In IDLE and DONE, dut_rst=0 and dut_d=0.
REQ-027 Run length SHALL be exactly RST_CYCLES+NUM_VECTORS+2 cycles from start acceptance to the done pulse, inclusive of DONE.

Reset
REQ-028 rst=1 SHALL asynchronously force state=IDLE, dut_rst=0, dut_d=0, busy=0, done=0, pass=0, err_count=0, exp_q=0, LFSR=8'h01, counters=0.
REQ-029 rst asserted mid-run SHALL abort the run with no done pulse; a new start is required after release.

Structure
REQ-030 Package dff_exer_pkg SHALL hold the state enum, LFSR tap mask 8'hB8 and the zero-seed replacement constant 8'h01.
REQ-031 LFSR SHALL be sub-module lfsr8 with ports clk, rst, load, seed, en, value[7:0].
REQ-032 Compare and count logic SHALL stay in dff_exerciser.

Verification
REQ-033 Ideal DFF, seed=8'h01, defaults: start -> dut_d sequence starts 4'h1,4'h2,4'h4,4'h8; done after 20 cycles; pass=1; err_count=0.
REQ-034 DUT Q stuck at 4'h0: seed=8'h01 -> err_count equals the number of nonzero expected values within the compare window; pass=0.
REQ-035 seed=8'h00 -> identical dut_d sequence to seed=8'h01.
REQ-036 rst pulsed in DRIVE cycle 5 -> outputs at reset values on the same cycle; no done pulse; a later start gives a full 20-cycle run.
REQ-037 start held high for 30 cycles -> exactly one run accepted per IDLE visit; start pulses while busy=1 are ignored.
REQ-038 DUT with Q inverted, NUM_VECTORS=255 -> err_count saturates at 255 and never wraps.

Source files
------------

// File: rtl/dff_exer_pkg.sv
// Shared types and constants for the DFF exerciser: FSM states, LFSR taps and seed handling.
package dff_exer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ASSERT_RST,
      DRIVE,
      DRAIN,
      DONE
   } state_e;

   // Taps for x^8+x^6+x^5+x^4+1 on a shift-left register (bits 7,5,4,3).
   localparam logic [7:0] LFSR_TAPS     = 8'hB8;
   localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/dff_exerciser_if.sv
// Run control, status and DFF-under-test signals of the exerciser; master is the exerciser side.
interface dff_exerciser_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [7:0]       seed;
   logic             busy;
   logic             done;
   logic             pass;
   logic [7:0]       err_count;
   logic             dut_rst;
   logic [WIDTH-1:0] dut_d;
   logic [WIDTH-1:0] dut_q;

   modport master (
      input  start, seed, dut_q,
      output busy, done, pass, err_count, dut_rst, dut_d
   );

   modport slave (
      output start, seed, dut_q,
      input  busy, done, pass, err_count, dut_rst, dut_d
   );
endinterface

// File: rtl/dff_exerciser_lfsr8.sv
// 8-bit Fibonacci LFSR; load has priority over advance, resets to 8'h01.
module lfsr8
   import dff_exer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       en,
   output logic [7:0] value
);

   logic [7:0] value_q;
   logic [7:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = seed;
      end else if (en) begin
         value_d = lfsr_next(value_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= SEED_ZERO_SUB;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/dff_exerciser.sv
// Drives reset then LFSR vectors into a DFF under test and counts Q mismatches against a one-cycle model.
// WIDTH must not exceed 8 (vectors are the low bits of the LFSR).
module dff_exerciser
   import dff_exer_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int NUM_VECTORS = 16,
   parameter int RST_CYCLES  = 2
) (
   input logic              clk,
   input logic              rst,
   dff_exerciser_if.master  bus
);

   localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
   localparam logic [7:0] NV_LAST  = 8'(NUM_VECTORS - 1);

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       err_q, err_d;
   logic             pass_q, pass_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] last_q, last_d;

   logic             lfsr_load;
   logic             lfsr_en;
   logic [7:0]       lfsr_seed;
   logic [7:0]       lfsr_val;
   logic             dut_rst_c;
   logic [WIDTH-1:0] dut_d_c;
   logic             cmp_en;

   assign lfsr_seed = (bus.seed == 8'h00) ? SEED_ZERO_SUB : bus.seed;

   lfsr8 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .seed  (lfsr_seed),
      .en    (lfsr_en),
      .value (lfsr_val)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      pass_d    = pass_q;
      last_d    = last_q;
      lfsr_load = 1'b0;
      lfsr_en   = 1'b0;
      dut_rst_c = 1'b0;
      dut_d_c   = '0;
      cmp_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = ASSERT_RST;
               cnt_d     = 8'd0;
               err_d     = 8'd0;
               pass_d    = 1'b0;
               lfsr_load = 1'b1;
            end
         end
         ASSERT_RST: begin
            dut_rst_c = 1'b1;
            // First reset cycle still sees Q from before the DUT was cleared.
            cmp_en    = (cnt_q != 8'd0);
            if (cnt_q == RST_LAST) begin
               cnt_d   = 8'd0;
               state_d = DRIVE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DRIVE: begin
            dut_d_c = WIDTH'(lfsr_val);
            last_d  = dut_d_c;
            lfsr_en = 1'b1;
            cmp_en  = 1'b1;
            if (cnt_q == NV_LAST) begin
               cnt_d   = 8'd0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DRAIN: begin
            dut_d_c = last_q;
            cmp_en  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            pass_d  = (err_q == 8'd0);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (cmp_en && (bus.dut_q != exp_q) && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   assign exp_d = dut_rst_c ? '0 : dut_d_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         err_q   <= 8'd0;
         pass_q  <= 1'b0;
         exp_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
         exp_q   <= exp_d;
         last_q  <= last_d;
      end
   end

   assign bus.dut_rst   = dut_rst_c;
   assign bus.dut_d     = dut_d_c;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;

endmodule

// File: tb/tb_dff_exerciser.sv
// Scoreboard bench: stimulus queues expected drive streams and run results, a negedge monitor checks them.
module tb_dff_exerciser;

   localparam int W       = 4;
   localparam int NV      = 16;
   localparam int RC      = 2;
   localparam int RUN_LEN = RC + NV + 2;
   localparam int BIG_NV  = 255;

   logic clk = 1'b0;
   logic rst;
   logic rst_big;
   always #5 clk = ~clk;

   dff_exerciser_if #(.WIDTH(W)) bus ();
   dff_exerciser_if #(.WIDTH(W)) bbus ();

   dff_exerciser #(.WIDTH(W), .NUM_VECTORS(NV), .RST_CYCLES(RC)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   dff_exerciser #(.WIDTH(W), .NUM_VECTORS(BIG_NV), .RST_CYCLES(RC)) u_big (
      .clk (clk),
      .rst (rst_big),
      .bus (bbus)
   );

   // DFF under test: 0 ideal, 1 Q stuck at zero, 2 Q inverted.
   int         mode;
   logic [W-1:0] dff_q  = '0;
   logic [W-1:0] bdff_q = '0;
   always @(posedge clk) dff_q  <= bus.dut_rst  ? '0 : bus.dut_d;
   always @(posedge clk) bdff_q <= bbus.dut_rst ? '0 : bbus.dut_d;
   assign bus.dut_q  = (mode == 1) ? '0 : (mode == 2) ? ~dff_q : dff_q;
   assign bbus.dut_q = ~bdff_q;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input longint act, input longint want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
      end
   endtask

   task automatic fail_event(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
   endtask

   typedef struct { logic r; logic [W-1:0] d; } drv_t;
   typedef struct { int err; int len; logic pass; } res_t;
   drv_t exp_drv[$];
   res_t exp_res[$];

   // Reference model: vector list from the polynomial, then per-cycle drive and compare window.
   task automatic issue_expect(input logic [7:0] s, input int m);
      int   v;
      int   vec[$];
      int   win[$];
      int   errs;
      int   resp;
      drv_t e;
      res_t r;
      v = (s == 0) ? 1 : int'(s);
      for (int k = 0; k < NV; k++) begin
         vec.push_back(v % (1 << W));
         v = ((v * 2) % 256) | (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
      end
      for (int k = 0; k < RC; k++) begin
         e.r = 1'b1; e.d = '0; exp_drv.push_back(e);
      end
      for (int k = 0; k < NV; k++) begin
         e.r = 1'b0; e.d = W'(vec[k]); exp_drv.push_back(e);
      end
      e.r = 1'b0; e.d = W'(vec[NV-1]); exp_drv.push_back(e);
      e.r = 1'b0; e.d = '0;            exp_drv.push_back(e);
      // Compared Q values: RC-1 reset cycles, first drive cycle (0), then every vector.
      for (int k = 0; k < RC; k++) win.push_back(0);
      foreach (vec[k]) win.push_back(vec[k]);
      errs = 0;
      foreach (win[k]) begin
         resp = (m == 0) ? win[k] : (m == 1) ? 0 : ((~win[k]) & ((1 << W) - 1));
         if (resp != win[k]) errs++;
      end
      if (errs > 255) errs = 255;
      r.err = errs; r.len = RUN_LEN; r.pass = (errs == 0);
      exp_res.push_back(r);
   endtask

   int   run_len = 0;
   logic pend_pass = 1'b0;
   logic pend_val  = 1'b0;

   always @(negedge clk) begin
      drv_t e;
      res_t r;
      if (rst) begin
         run_len   = 0;
         pend_pass = 1'b0;
      end else begin
         if (pend_pass) begin
            check("pass", bus.pass, pend_val);
            pend_pass = 1'b0;
         end
         if (bus.busy) begin
            run_len++;
            if (exp_drv.size() == 0) begin
               fail_event("stray_busy");
            end else begin
               e = exp_drv.pop_front();
               check("dut_rst", bus.dut_rst, e.r);
               check("dut_d", bus.dut_d, e.d);
            end
         end else begin
            check("idle_dut_rst", bus.dut_rst, 0);
            check("idle_dut_d", bus.dut_d, 0);
            run_len = 0;
         end
         if (bus.done) begin
            if (exp_res.size() == 0) begin
               fail_event("stray_done");
            end else begin
               r = exp_res.pop_front();
               check("err_count", bus.err_count, r.err);
               check("run_len", run_len, r.len);
               pend_pass = 1'b1;
               pend_val  = r.pass;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_drv.size() != 0 || exp_res.size() != 0 || bus.busy) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) fail_event("drain_timeout");
   endtask

   task automatic run(input logic [7:0] s, input int m, input bit noise);
      wait_idle(600);
      mode = m;
      issue_expect(s, m);
      bus.seed  = s;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      if (noise) begin
         for (int k = 0; k < RC + NV; k++) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.seed  = 8'($urandom);
            tick();
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_pass"}, bus.pass, 0);
      check({tag, "_err"}, bus.err_count, 0);
      check({tag, "_dut_rst"}, bus.dut_rst, 0);
      check({tag, "_dut_d"}, bus.dut_d, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int big_exp;
      int n;
      int prev;
      rst = 1'b1; rst_big = 1'b1; mode = 0;
      bus.start = 1'b0;  bus.seed = 8'h00;
      bbus.start = 1'b0; bbus.seed = 8'h00;
      #1;
      check_reset_outputs("reset");
      tick(); tick();
      rst = 1'b0; rst_big = 1'b0;
      tick();

      run(8'h01, 0, 0);
      run(8'h01, 1, 0);
      run(8'h00, 0, 0);
      run(8'h00, 2, 0);
      for (int i = 0; i < 6; i++) begin
         run(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), int'($urandom_range(0, 2)), 1);
      end

      // Abort in the fifth drive cycle of a stuck-Q run.
      wait_idle(600);
      mode = 1;
      issue_expect(8'h01, 1);
      bus.seed = 8'h01; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (RC + 4) tick();
      rst = 1'b1;
      #1;
      check_reset_outputs("abort");
      exp_drv.delete();
      exp_res.delete();
      tick();
      rst = 1'b0;
      repeat (30) tick();
      run(8'h01, 0, 0);

      // Start held high: a run is accepted at every IDLE visit within the window.
      wait_idle(600);
      mode = 0;
      bus.seed = 8'hC3;
      for (int t = 0; t < 30; t += RUN_LEN + 1) issue_expect(8'hC3, 0);
      bus.start = 1'b1;
      repeat (30) tick();
      bus.start = 1'b0;
      wait_idle(600);
      repeat (2) tick();

      // Inverted Q over 255 vectors: counter must saturate and never wrap.
      big_exp = (RC + BIG_NV > 255) ? 255 : RC + BIG_NV;
      bbus.seed = 8'h5A; bbus.start = 1'b1;
      tick();
      bbus.start = 1'b0;
      n = 1;
      prev = 0;
      while (!bbus.done && n < 400) begin
         check("big_err_monotonic", int'(bbus.err_count) >= prev, 1);
         prev = int'(bbus.err_count);
         tick();
         n++;
      end
      check("big_run_len", n, RC + BIG_NV + 2);
      check("big_err_count", bbus.err_count, big_exp);
      tick();
      check("big_pass", bbus.pass, 0);
      check("big_err_hold", bbus.err_count, big_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
